jt900h_membus: RTL and testbench

- Bridge between the jt900h core's zero-wait RAM port (ram_addr/ram_din/ram_dout/ram_we) and an external memory that takes a variable number of cycles (SDRAM/BRAM arbiter).
- Holds the CPU by gating its clock enable until each access completes.
- Keeps a one-word read buffer so repeated reads of the same word (e.g. opcode refetch) need no memory transaction.
- Has a timeout watchdog so the CPU cannot hang on a dead bus.

---
 rtl/jt900h_membus.sv | 145 ++++++++++++++
 tb/tb_jt900h_membus.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_membus.sv
// Bridge between the jt900h zero-wait RAM port and a variable-latency memory.
// Stalls the core through its clock enable, buffers one read word and aborts dead accesses.
module jt900h_membus #(
    parameter int unsigned TOUT = 255,
    parameter int unsigned TW   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        flush,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_wmask,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ok,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q;
    logic          valid_q;
    logic [22:0]   tag_q;
    logic [15:0]   data_q;
    logic [TW-1:0] cnt_q;
    logic          mem_cs_q;
    logic          mem_we_q;
    logic [22:0]   mem_addr_q;
    logic [1:0]    mem_wmask_q;
    logic [15:0]   mem_wdata_q;
    logic          bus_err_q;

    logic          hit;
    logic          pass;
    logic          timeout;
    logic [TW-1:0] cnt_d;
    logic [15:0]   merge_d;
    logic          unused_addr_lsb;

    // Byte address bit 0 has no meaning on a 16-bit word bus.
    assign unused_addr_lsb = cpu_addr[0];

    assign hit     = valid_q && (tag_q == cpu_addr[23:1]) && (cpu_we == 2'b00) && !flush;
    assign pass    = ((state_q == IDLE) && hit) || (state_q == DONE);
    assign cpu_cen = cen & pass;
    assign timeout = (cnt_q == TW'(TOUT - 1));
    assign cnt_d   = cnt_q + TW'(1);
    assign merge_d = {mem_wmask_q[1] ? mem_wdata_q[15:8] : data_q[15:8],
                      mem_wmask_q[0] ? mem_wdata_q[7:0]  : data_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: later non-blocking writes to valid_q override this one, so a read
            // completing in the same cycle as flush leaves the fresh word valid.
            if (flush) valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cen) begin
                        if (cpu_we != 2'b00) begin
                            state_q     <= WR;
                            mem_addr_q  <= cpu_addr[23:1];
                            mem_wdata_q <= cpu_wdata;
                            mem_wmask_q <= cpu_we;
                            mem_we_q    <= 1'b1;
                            mem_cs_q    <= 1'b1;
                            cnt_q       <= '0;
                        end else if (!hit) begin
                            state_q     <= RD;
                            mem_addr_q  <= cpu_addr[23:1];
                            mem_wmask_q <= 2'b00;
                            mem_we_q    <= 1'b0;
                            mem_cs_q    <= 1'b1;
                            cnt_q       <= '0;
                        end
                    end
                end
                RD: begin
                    if (mem_ok) begin
                        data_q   <= mem_rdata;
                        tag_q    <= mem_addr_q;
                        valid_q  <= 1'b1;
                        mem_cs_q <= 1'b0;
                        state_q  <= DONE;
                    end else if (timeout) begin
                        data_q    <= 16'hFFFF;
                        valid_q   <= 1'b0;
                        mem_cs_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WR: begin
                    if (mem_ok) begin
                        mem_cs_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= DONE;
                        // Keep the buffered word coherent with what memory now holds.
                        if (valid_q && (tag_q == mem_addr_q)) data_q <= merge_d;
                    end else if (timeout) begin
                        mem_cs_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    if (cen) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = data_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_jt900h_membus.sv
// Bench for jt900h_membus: directed and random CPU accesses against a word-memory model
// with a latency-programmable responder; cache state is predicted at the transaction level.
module tb_jt900h_membus;

    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        flush = 1'b0;
    logic        cpu_cen;
    logic [23:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [1:0]  cpu_we = '0;
    logic [15:0] cpu_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ok = 1'b0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    jt900h_membus #(.TOUT(TOUT), .TW(16)) dut (
        .clk(clk), .rst(rst), .cen(cen), .flush(flush), .cpu_cen(cpu_cen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ok(mem_ok), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // cen source: 0 = always on, 1 = every 4th clk, 2 = off
    int cen_mode = 2;
    int ph = 0;
    always @(posedge clk) begin
        #2;
        ph = (ph + 1) % 4;
        case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = (ph == 0);
            default: cen = 1'b0;
        endcase
    end

    function automatic logic [15:0] init_val(input int w);
        return 16'(w * 37) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] nw,
                                            input logic [1:0] m);
        return {m[1] ? nw[15:8] : old[15:8], m[0] ? nw[7:0] : old[7:0]};
    endfunction

    // Physical memory seen by the responder, updated only through the DUT's bus.
    logic [15:0] phys [int];
    int  mem_lat = 1;
    bit  mem_dead = 1'b0;
    bit  force_ok = 1'b0;
    int  wcnt = 0;

    always @(posedge clk) begin
        #2;
        if (force_ok) begin
            mem_ok    = 1'b1;
            mem_rdata = 16'h1357;
            force_ok  = 1'b0;
        end else if (mem_ok) begin
            mem_ok = 1'b0;
            wcnt   = 0;
        end else if (mem_cs && !mem_dead) begin
            wcnt++;
            if (wcnt >= mem_lat) begin
                mem_ok = 1'b1;
                wcnt   = 0;
                if (mem_we)
                    phys[int'(mem_addr)] = merge16(phys.exists(int'(mem_addr)) ?
                        phys[int'(mem_addr)] : init_val(int'(mem_addr)), mem_wdata, mem_wmask);
                else
                    mem_rdata = phys.exists(int'(mem_addr)) ? phys[int'(mem_addr)]
                                                             : init_val(int'(mem_addr));
            end
        end else if (!mem_cs) begin
            wcnt = 0;
        end
    end

    // CPU-level reference: memory contents as the program sees them, plus buffer presence.
    logic [15:0] model [int];
    bit b_valid = 1'b0;
    int b_tag = 0;
    bit exp_err = 1'b0;

    function automatic logic [15:0] model_rd(input int w);
        return model.exists(w) ? model[w] : init_val(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access: holds the request until cpu_cen pulses, then lets the core advance.
    task automatic access(input logic [23:0] addr, input logic [1:0] we, input logic [15:0] wdata,
                          input int lat, input int fl_at, input bit dead, input string tag);
        int k;
        bit exp_hit;
        bit fl_done;
        bit prev_cs;
        bit done;
        int stalls;
        int reqs;
        int cyc;
        int exp_stalls;
        k = int'(addr[23:1]);
        mem_lat   = lat;
        mem_dead  = dead;
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_wdata = wdata;
        exp_hit   = (we == 2'b00) && b_valid && (b_tag == k) && (fl_at != 0);
        fl_done   = (fl_at == 0);
        flush     = fl_done;
        prev_cs = 1'b0; done = 1'b0; stalls = 0; reqs = 0; cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            check({tag, "/cen_gate"}, 32'(cpu_cen & ~cen), 0);
            if (mem_cs) begin
                check({tag, "/mem_addr"}, 32'(mem_addr), 32'(addr[23:1]));
                check({tag, "/mem_we"}, 32'(mem_we), 32'(we != 2'b00));
                check({tag, "/mem_wmask"}, 32'(mem_wmask), 32'(we));
                if (we != 2'b00) check({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(wdata));
                if (!prev_cs) reqs++;
            end
            prev_cs = mem_cs;
            if (cpu_cen) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
                cyc++;
                flush = (cyc == fl_at);
                if (flush) fl_done = 1'b1;
            end
        end
        check({tag, "/released"}, 32'(done), 1);
        check({tag, "/requests"}, reqs, exp_hit ? 0 : 1);
        if (cen_mode == 0) begin
            exp_stalls = exp_hit ? 0 : (dead ? TOUT + 1 : lat + 1);
            check({tag, "/stalls"}, stalls, exp_stalls);
        end
        if (dead) exp_err = 1'b1;
        if (we == 2'b00) begin
            check({tag, "/rdata"}, 32'(cpu_rdata), dead ? 32'hFFFF : 32'(model_rd(k)));
            b_valid = !dead;
            b_tag   = k;
        end else begin
            if (!dead) model[k] = merge16(model_rd(k), wdata, we);
            if (fl_done) b_valid = 1'b0;
        end
        check({tag, "/bus_err"}, 32'(bus_err), 32'(exp_err));
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/cpu_cen"}, 32'(cpu_cen), 0);
        check({tag, "/mem_cs"}, 32'(mem_cs), 0);
        check({tag, "/mem_we"}, 32'(mem_we), 0);
        check({tag, "/mem_addr"}, 32'(mem_addr), 0);
        check({tag, "/mem_wmask"}, 32'(mem_wmask), 0);
        check({tag, "/mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "/cpu_rdata"}, 32'(cpu_rdata), 0);
        check({tag, "/bus_err"}, 32'(bus_err), 0);
    endtask

    initial begin
        logic [23:0] a;
        logic [1:0]  w;
        int          l;
        int          f;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cen_mode = 0;

        // Read miss, then a hit on the other byte of the same word
        model[24'h00091A] = 16'hBEEF;
        phys[24'h00091A]  = 16'hBEEF;
        access(24'h001234, 2'b00, 16'h0000, 3, -1, 1'b0, "miss");
        access(24'h001235, 2'b00, 16'h0000, 3, -1, 1'b0, "hit");

        // Byte writes merge into the buffered word
        access(24'h001234, 2'b01, 16'h0055, 1, -1, 1'b0, "wr_lo");
        access(24'h001234, 2'b00, 16'h0000, 1, -1, 1'b0, "hit_lo");
        check("merged_lo", 32'(cpu_rdata), 32'h0000BE55);
        access(24'h001235, 2'b10, 16'hA700, 2, -1, 1'b0, "wr_hi");
        access(24'h001235, 2'b00, 16'h0000, 1, -1, 1'b0, "hit_hi");

        // mem_ok on the timeout cycle completes normally
        access(24'h002000, 2'b00, 16'h0000, TOUT, -1, 1'b0, "ok_at_tout");

        // Dead bus: abort, sticky error, next read of the word misses
        access(24'h004000, 2'b00, 16'h0000, 1, -1, 1'b1, "timeout");
        access(24'h004000, 2'b00, 16'h0000, 2, -1, 1'b0, "after_tout");

        // Flush forces a miss; flush on the completion cycle keeps the new word
        access(24'h004000, 2'b00, 16'h0000, 1, 0, 1'b0, "flush_idle");
        access(24'h006000, 2'b00, 16'h0000, 2, 2, 1'b0, "flush_done");
        access(24'h006000, 2'b00, 16'h0000, 2, -1, 1'b0, "flush_kept");
        access(24'h008000, 2'b11, 16'h1234, 3, 1, 1'b0, "flush_wr");
        access(24'h006000, 2'b00, 16'h0000, 2, -1, 1'b0, "flush_lost");

        // cen throttled to every 4th clk
        cen_mode = 1;
        for (int i = 0; i < 16; i++) begin
            a = {23'(32'h100 + $urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            w = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            f = ($urandom_range(0, 5) == 0) ? 0 : -1;
            access(a, w, 16'($urandom), 1, f, 1'b0, "throttle");
        end
        cen_mode = 0;

        // Random traffic at full cen with assorted latencies and flushes
        for (int i = 0; i < 40; i++) begin
            a = {23'(32'h100 + $urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            w = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            l = $urandom_range(1, TOUT);
            f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
            access(a, w, 16'($urandom), l, f, 1'b0, "random");
        end

        // Reset in the middle of a read, with the memory answering afterwards
        mem_dead = 1'b1;
        cpu_addr = 24'h000600;
        cpu_we   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstb/pending_cs", 32'(mem_cs), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cen_mode = 2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ok = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstb_now");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rstb_late_ok");
        @(posedge clk);
        #1;
        b_valid  = 1'b0;
        exp_err  = 1'b0;
        mem_dead = 1'b0;
        cen_mode = 0;
        access(24'h000600, 2'b00, 16'h0000, 2, -1, 1'b0, "rstb_miss");
        check("rstb_not_late", 32'(cpu_rdata == 16'h1357), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
